muldiv_seq: RTL

Parametrised iterative multiply/divide sequencer with its own HI/LO register pair, sitting beside the ALU in the execute stage. It decodes the R-type funct codes the ALU decoder does not cover: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It runs one multiply or divide bit-step per cycle at a configurable datapath width. A busy/stall/done handshake freezes the pipeline while an operation is in flight.

---
 rtl/muldiv_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit with private HI/LO registers.
// One shift-add or restoring-divide bit-step per cycle; busy/stall/done handshake to the pipeline.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MTHI = 6'b010001;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MTLO = 6'b010011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;

    logic               is_muldiv;
    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Funct 0110xx are the four mul/div codes; bit 0 clear means signed, bit 1 set means divide.
    always_comb begin
        is_muldiv  = (funct[5:2] == 4'b0110);
        is_signed  = ~funct[0];
        abs_a      = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b      = (is_signed && b[WIDTH-1]) ? -b : b;
        mul_addend = prod[0] ? mag_a : {WIDTH{1'b0}};
        mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        // The shifted partial remainder is the WIDTH+1-bit working remainder of the restoring step.
        div_shift  = {rem, mag_a[WIDTH-1]};
        div_diff   = {1'b0, div_shift} - {2'b00, mag_b};
        prod_fix   = neg_q ? -prod : prod;
        q_fix      = neg_q ? -mag_a : mag_a;
        r_fix      = neg_r ? -rem : rem;
    end

    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (funct == FN_MFHI) begin
            rdata = hi;
        end else if (funct == FN_MFLO) begin
            rdata = lo;
        end
    end

    assign busy  = (state != IDLE);
    assign stall = start & busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            prod     <= '0;
            rem      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_muldiv) begin
                        state    <= RUN;
                        cnt      <= CW'(WIDTH);
                        op_div   <= funct[1];
                        neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= is_signed & a[WIDTH-1];
                        div_zero <= (b == '0);
                        a_raw    <= a;
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        prod     <= {{WIDTH{1'b0}}, abs_b};
                        rem      <= '0;
                    end else if (start && funct == FN_MTHI) begin
                        hi <= a;
                    end else if (start && funct == FN_MTLO) begin
                        lo <= a;
                    end
                end
                // Divide shifts quotient bits into mag_a as the dividend bits leave it.
                RUN: begin
                    if (op_div) begin
                        if (div_diff[WIDTH+1]) begin
                            rem <= div_shift[WIDTH-1:0];
                        end else begin
                            rem <= div_diff[WIDTH-1:0];
                        end
                        mag_a <= {mag_a[WIDTH-2:0], ~div_diff[WIDTH+1]};
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (!op_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        lo <= {WIDTH{1'b1}};
                        hi <= a_raw;
                    end else begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
